pid_channel_scheduler: RTL

Time-shares one pid_core datapath between N_CH oversample-filter channels. Per-channel samples are latched as pending. A round-robin scheduler issues one sample at a time to the core, together with the channel index the core-side parameter bank uses to select coefficients. The scheduler waits for the core's result and returns it tagged with its channel. Sits between the oversample filters and pid_core on the input side, and between pid_core and the source mux on the output side.

---
 rtl/pid_channel_scheduler_pkg.sv | 30 +++
 rtl/pid_channel_scheduler_rr_arbiter.sv | 36 +++
 rtl/pid_channel_scheduler.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/pid_channel_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// pid_channel_scheduler_pkg
// Shared definitions for the pid_core channel scheduler:
//   - state_t     : scheduler FSM encoding
//   - MAX_TIMEOUT : largest supported core-response timeout
//   - W_CNT       : width of the response-wait counter
//   - clog2()     : ceil(log2(value)), usable in parameter expressions
// ---------------------------------------------------------------------------
package pid_channel_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_SEND  = 2'd3
  } state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  localparam int MAX_TIMEOUT = 255;
  localparam int W_CNT       = clog2(MAX_TIMEOUT + 1);

endpackage

// File: rtl/pid_channel_scheduler_rr_arbiter.sv
// ---------------------------------------------------------------------------
// pid_channel_scheduler_rr_arbiter
// Purely combinational round-robin picker. Searches the request vector
// starting one position above the pointer and wrapping modulo N_CH.
// Ports:
//   req_i         : per-channel request (pending) bits
//   ptr_i         : last granted channel
//   grant_o       : index of the chosen channel (0 when nothing requested)
//   grant_valid_o : at least one request was present
// ---------------------------------------------------------------------------
module pid_channel_scheduler_rr_arbiter
  import pid_channel_scheduler_pkg::*;
#(
  parameter int N_CH = 8,
  parameter int W_CH = 3
) (
  input  logic [N_CH-1:0] req_i,
  input  logic [W_CH-1:0] ptr_i,
  output logic [W_CH-1:0] grant_o,
  output logic            grant_valid_o
);

  // Walk offsets from farthest to nearest so the closest request after the
  // pointer is the last one written and therefore wins.
  always_comb begin
    grant_o       = '0;
    grant_valid_o = 1'b0;
    for (int i = N_CH; i >= 1; i--) begin
      if (req_i[(int'(ptr_i) + i) % N_CH]) begin
        grant_o       = W_CH'((int'(ptr_i) + i) % N_CH);
        grant_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pid_channel_scheduler.sv
// ---------------------------------------------------------------------------
// pid_channel_scheduler
// Time-shares one pid_core between N_CH filter channels. Incoming samples are
// latched as pending, a round-robin arbiter picks one at a time, the sample is
// issued to the core with its channel index, and the core's result is
// returned tagged with that channel. One transaction in flight at a time.
// Ports:
//   clk_in, reset_in          : clock, async active-high reset
//   data_in, data_valid_in    : packed per-channel samples and strobes
//   clear_in                  : per-channel clear of pending/overrun
//   core_data_out/_valid_out  : sample issued to pid_core (one-cycle strobe)
//   core_chan_out             : channel the core must use for this sample
//   core_data_in/_valid_in    : pid_core result
//   data_out/data_valid_out   : result to the source mux (one-cycle strobe)
//   chan_out                  : channel tag of data_out
//   overrun_out               : sticky per-channel overwrite flag
//   timeout_out               : one-cycle pulse when the core never answered
// ---------------------------------------------------------------------------
module pid_channel_scheduler
  import pid_channel_scheduler_pkg::*;
#(
  parameter int N_CH    = 8,
  parameter int W_CH    = clog2(N_CH),
  parameter int W_IN    = 18,
  parameter int W_OUT   = 64,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk_in,
  input  logic                 reset_in,
  input  logic [N_CH*W_IN-1:0] data_in,
  input  logic [N_CH-1:0]      data_valid_in,
  input  logic [N_CH-1:0]      clear_in,
  output logic [W_IN-1:0]      core_data_out,
  output logic                 core_data_valid_out,
  output logic [W_CH-1:0]      core_chan_out,
  input  logic [W_OUT-1:0]     core_data_in,
  input  logic                 core_data_valid_in,
  output logic [W_OUT-1:0]     data_out,
  output logic                 data_valid_out,
  output logic [W_CH-1:0]      chan_out,
  output logic [N_CH-1:0]      overrun_out,
  output logic                 timeout_out
);

  localparam logic [W_CNT-1:0] TO_LAST = W_CNT'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [W_CH-1:0]   ptr_q;
  logic [W_CH-1:0]   grant_q;
  logic [N_CH-1:0]   pending_q, pending_d;
  logic [N_CH-1:0]   overrun_q, overrun_d;
  logic [W_IN-1:0]   sample_q [N_CH];
  logic [W_IN-1:0]   issue_q;
  logic [W_CNT-1:0]  cnt_q;
  logic [W_OUT-1:0]  result_q;
  logic [W_CH-1:0]   chan_q;
  logic              timeout_q;

  logic [W_CH-1:0]   arb_grant;
  logic              arb_valid;
  logic              grab;
  logic              timeout_hit;
  logic              result_take;
  logic [N_CH-1:0]   grant_onehot;

  pid_channel_scheduler_rr_arbiter #(
    .N_CH (N_CH),
    .W_CH (W_CH)
  ) u_arb (
    .req_i         (pending_q),
    .ptr_i         (ptr_q),
    .grant_o       (arb_grant),
    .grant_valid_o (arb_valid)
  );

  assign grab         = (state_q == ST_IDLE) && arb_valid;
  assign grant_onehot = grab ? (N_CH'(1) << arb_grant) : '0;
  assign result_take  = (state_q == ST_WAIT) && core_data_valid_in;
  assign timeout_hit  = (state_q == ST_WAIT) && !core_data_valid_in && (cnt_q == TO_LAST);

  // Next-state and strobe outputs; strobes are pure functions of the state.
  always_comb begin
    state_d             = state_q;
    core_data_valid_out = 1'b0;
    data_valid_out      = 1'b0;
    case (state_q)
      ST_IDLE:  if (arb_valid) state_d = ST_ISSUE;
      ST_ISSUE: begin
        core_data_valid_out = 1'b1;
        state_d             = ST_WAIT;
      end
      ST_WAIT: begin
        if (core_data_valid_in)   state_d = ST_SEND;
        else if (cnt_q == TO_LAST) state_d = ST_IDLE;
      end
      ST_SEND: begin
        data_valid_out = 1'b1;
        state_d        = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Pending/overrun update. Clear beats capture; a capture on the grant
  // cycle re-arms pending but is not an overrun because the old sample is
  // being consumed in that same cycle.
  always_comb begin
    pending_d = pending_q;
    overrun_d = overrun_q;
    for (int k = 0; k < N_CH; k++) begin
      if (clear_in[k]) begin
        pending_d[k] = 1'b0;
        overrun_d[k] = 1'b0;
      end else if (data_valid_in[k]) begin
        if (pending_q[k] && !grant_onehot[k]) overrun_d[k] = 1'b1;
        pending_d[k] = 1'b1;
      end else if (grant_onehot[k]) begin
        pending_d[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q   <= ST_IDLE;
      ptr_q     <= W_CH'(N_CH - 1);
      grant_q   <= '0;
      pending_q <= '0;
      overrun_q <= '0;
      issue_q   <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      chan_q    <= '0;
      timeout_q <= 1'b0;
      for (int k = 0; k < N_CH; k++) sample_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_hit;
      for (int k = 0; k < N_CH; k++) begin
        if (data_valid_in[k] && !clear_in[k]) sample_q[k] <= data_in[k*W_IN +: W_IN];
      end
      // sample_q still holds the old value here, so a same-cycle capture
      // for the granted channel does not leak into the issue register.
      if (grab) begin
        grant_q <= arb_grant;
        ptr_q   <= arb_grant;
        issue_q <= sample_q[arb_grant];
      end
      if (state_q == ST_ISSUE) cnt_q <= '0;
      else if (state_q == ST_WAIT) cnt_q <= cnt_q + 1'b1;
      if (result_take) begin
        result_q <= core_data_in;
        chan_q   <= grant_q;
      end
    end
  end

  assign core_data_out = issue_q;
  assign core_chan_out = grant_q;
  assign data_out      = result_q;
  assign chan_out      = chan_q;
  assign overrun_out   = overrun_q;
  assign timeout_out   = timeout_q;

endmodule
